calc_seq_unit: RTL and testbench
================================

Name: calc_seq_unit

Overview:
- Parametrised, clocked successor to the team's combinational 4-op calculator.
- Accepts one operand pair plus an opcode per transaction over a valid/ready handshake.
- Add, sub and mul return in one cycle; unsigned divide runs as a W-cycle restoring divider that also returns the remainder.
- Sits between operand registers/UART command decoder and the display/result logic in the lab datapath.

Parameters:
- W, 6, operand width in bits (legal 2..16).
- CNT_W, $clog2(W)+1, width of the internal divide iteration counter (derived; not overridden).

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request this cycle
- i_op  in  2  opcode: 0=add, 1=sub, 2=mul, 3=div
- i_data1  in  W  operand A (dividend for div)
- i_data2  in  W  operand B (divisor for div)
- o_valid  out  1  one-cycle pulse, result fields valid
- o_result  out  2W  result (see width rules)
- o_rem  out  W  divide remainder; 0 for non-div ops
- o_div_zero  out  1  divide-by-zero flag, qualified by o_valid

Behaviour:
- One clock (i_clk); reset i_rst is synchronous and active-high.
- Reset: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_rem=0, o_div_zero=0, counter=0.
- Accept: i_valid && o_ready at a rising edge; operands and opcode are captured on that edge. i_valid while o_ready=0 is ignored (not queued).
- FSM states:
  - IDLE: o_ready=1. On accept of add/sub/mul, or div with i_data2==0 -> DONE. On accept of div with i_data2!=0 -> DIV.
  - DIV: o_ready=0; one restoring iteration per cycle, MSB first, for W cycles; counter W-1 down to 0; at 0 -> DONE.
  - DONE: o_valid=1 for exactly this cycle, o_ready=0 -> IDLE.
- o_valid has no back-pressure; the consumer must sample it on the pulse.
- Latency from accept edge to o_valid high:
  - add/sub/mul/div-by-zero: 1 cycle.
  - div: W+1 cycles.
- Throughput: one request per 2 cycles (add/sub/mul), one per W+2 cycles (div).
- Arithmetic, all operands unsigned:
  - add: W+1-bit sum, zero-extended to 2W.
  - sub: A-B computed in W+1 bits two's complement, sign-extended to 2W (so 5-6 gives all ones).
  - mul: full 2W-bit product.
  - div: quotient in o_result[W-1:0], upper bits 0; remainder on o_rem.
- Divide by zero: o_div_zero=1, o_result[W-1:0] all ones, upper bits 0, o_rem=A.
- o_div_zero is 0 for every other result.
- Hold: o_result/o_rem/o_div_zero hold their last values until the next DONE. Values are undefined-free (registered) outside the o_valid pulse.
- Reset mid-operation: i_rst during DIV or DONE aborts the operation, produces no o_valid pulse, and forces all reset values on the next edge. Reset wins over a simultaneous accept.

Test Plan:
- W=6, reset held 2 cycles, then released -> o_ready=1, o_valid=0, o_result=0, o_rem=0, o_div_zero=0.
- add 4+2; then sub 5-6 -> add: o_valid 1 cycle after accept, o_result=6. sub: o_result=12'hFFF, o_rem=0.
- mul 63*63 -> o_result=3969 (12'hF81) after 1 cycle.
- div 7/2 -> o_ready low 7 cycles; o_valid 7 cycles after accept; o_result=3, o_rem=1, o_div_zero=0.
- div 9/0 -> o_valid after 1 cycle; o_result=63, o_rem=9, o_div_zero=1.
- div 45/4 with i_valid (add 1+1) asserted on cycles 2-4 -> add ignored; single o_valid with o_result=11, o_rem=1.
- div 45/4 with i_rst pulsed on cycle 3 -> no o_valid; all outputs 0; o_ready=1 next cycle; a following add 1+1 returns 2.

Source files
------------

// File: rtl/calc_seq_unit.sv
// Clocked add/sub/mul/div unit: add/sub/mul/div-by-zero answer 1 cycle after accept, divide W+1 cycles.
// o_ready is high only in IDLE; requests offered while busy are dropped, and o_valid is a single unthrottled pulse.
module calc_seq_unit #(
    parameter int W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [W-1:0]     i_data1,
    input  logic [W-1:0]     i_data2,
    output logic             o_valid,
    output logic [2*W-1:0]   o_result,
    output logic [W-1:0]     o_rem,
    output logic             o_div_zero
);
    localparam int CNT_W = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [W-1:0]       dvd_q;    // dividend shifting out MSB-first, quotient shifting in
    logic [W-1:0]       dvs_q;
    logic [W-1:0]       part_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*W-1:0]     res_q;
    logic [W-1:0]       rem_q;
    logic               dz_q;

    logic               accept;
    logic               div_zero_req;
    logic [W:0]         sum;
    logic [W:0]         diff;
    logic [2*W-1:0]     prod;
    logic [W:0]         trial;
    logic               q_bit;
    logic [W-1:0]       part_nxt;
    logic [W-1:0]       quo_nxt;

    assign accept       = i_valid && (state == IDLE);
    assign div_zero_req = (i_op == 2'd3) && (i_data2 == '0);

    assign sum  = {1'b0, i_data1} + {1'b0, i_data2};
    assign diff = {1'b0, i_data1} - {1'b0, i_data2};
    assign prod = (2*W)'(i_data1) * (2*W)'(i_data2);

    // Partial remainder stays below the divisor, so W+1 bits hold the trial and its sign.
    assign trial    = {part_q, dvd_q[W-1]} - {1'b0, dvs_q};
    assign q_bit    = ~trial[W];
    assign part_nxt = q_bit ? trial[W-1:0] : {part_q[W-2:0], dvd_q[W-1]};
    assign quo_nxt  = {dvd_q[W-2:0], q_bit};

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (i_op == 2'd3 && !div_zero_req) ? DIV : DONE;
            DIV:  if (cnt_q == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            part_q <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dvd_q  <= i_data1;
                    dvs_q  <= i_data2;
                    part_q <= '0;
                    cnt_q  <= CNT_W'(W - 1);
                    case (i_op)
                        2'd0: begin res_q <= {{(W-1){1'b0}}, sum};     rem_q <= '0; dz_q <= 1'b0; end
                        2'd1: begin res_q <= {{(W-1){diff[W]}}, diff}; rem_q <= '0; dz_q <= 1'b0; end
                        2'd2: begin res_q <= prod;                     rem_q <= '0; dz_q <= 1'b0; end
                        default: if (div_zero_req) begin
                            res_q <= {{W{1'b0}}, {W{1'b1}}};
                            rem_q <= i_data1;
                            dz_q  <= 1'b1;
                        end
                    endcase
                end
                DIV: begin
                    dvd_q  <= quo_nxt;
                    part_q <= part_nxt;
                    if (cnt_q == '0) begin
                        res_q <= {{W{1'b0}}, quo_nxt};
                        rem_q <= part_nxt;
                        dz_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result   = res_q;
    assign o_rem      = rem_q;
    assign o_div_zero = dz_q;

endmodule

// File: tb/tb_calc_seq_unit.sv
// Directed-vector bench for calc_seq_unit with a queue scoreboard and an independent output monitor.
module tb_calc_seq_unit;
    localparam int W = 6;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_op;
    logic [W-1:0]     i_data1;
    logic [W-1:0]     i_data2;
    logic             o_valid;
    logic [2*W-1:0]   o_result;
    logic [W-1:0]     o_rem;
    logic             o_div_zero;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic [W-1:0]   rem;
        logic           dz;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    calc_seq_unit #(.W(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_data1    (i_data1),
        .i_data2    (i_data2),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_rem      (o_rem),
        .o_div_zero (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: cycle count advances on every falling edge, outputs sampled there.
    always @(negedge i_clk) begin
        exp_t e;
        cyc++;
        if (o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: o_result=%0h with no pending request (cycle %0d)", o_result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result",   32'(o_result),   32'(e.res));
                chk("rem",      32'(o_rem),      32'(e.rem));
                chk("div_zero", 32'(o_div_zero), 32'(e.dz));
                chk("latency",  32'(cyc),        32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] r, input logic [W-1:0] rm, input logic dz,
                         input int lat, input bit track);
        exp_t e;
        int   g;
        g = 0;
        @(negedge i_clk); #1;
        while (!o_ready && g < 100) begin
            @(negedge i_clk); #1;
            g++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: o_ready=0 expected 1 within 100 cycles");
        end
        i_valid = 1'b1;
        i_op    = op;
        i_data1 = a;
        i_data2 = b;
        if (track) begin
            e.res = r; e.rem = rm; e.dz = dz; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    initial begin
        int lowcnt;
        i_rst = 1'b1; i_valid = 1'b0; i_op = 2'd0; i_data1 = '0; i_data2 = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        chk("rst_ready",  32'(o_ready),    32'd1);
        chk("rst_valid",  32'(o_valid),    32'd0);
        chk("rst_result", 32'(o_result),   32'd0);
        chk("rst_rem",    32'(o_rem),      32'd0);
        chk("rst_dz",     32'(o_div_zero), 32'd0);

        issue(2'd0, 6'd4,  6'd2,  12'd6,    6'd0, 1'b0, 1, 1'b1);
        issue(2'd1, 6'd5,  6'd6,  12'hFFF,  6'd0, 1'b0, 1, 1'b1);
        issue(2'd2, 6'd63, 6'd63, 12'hF81,  6'd0, 1'b0, 1, 1'b1);
        issue(2'd0, 6'd63, 6'd63, 12'd126,  6'd0, 1'b0, 1, 1'b1);
        issue(2'd1, 6'd63, 6'd0,  12'd63,   6'd0, 1'b0, 1, 1'b1);
        issue(2'd2, 6'd0,  6'd37, 12'd0,    6'd0, 1'b0, 1, 1'b1);

        issue(2'd3, 6'd7, 6'd2, 12'd3, 6'd1, 1'b0, W + 1, 1'b1);
        lowcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk); #1;
            if (o_ready) break;
            lowcnt++;
        end
        chk("div_busy_cycles", 32'(lowcnt), 32'd7);

        issue(2'd3, 6'd9,  6'd0, 12'd63, 6'd9, 1'b1, 1,     1'b1);
        issue(2'd3, 6'd63, 6'd1, 12'd63, 6'd0, 1'b0, W + 1, 1'b1);
        issue(2'd3, 6'd5,  6'd9, 12'd0,  6'd5, 1'b0, W + 1, 1'b1);

        // Requests offered while the divider is busy must be dropped.
        issue(2'd3, 6'd45, 6'd4, 12'd11, 6'd1, 1'b0, W + 1, 1'b1);
        @(negedge i_clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk); #1;
            chk("busy_not_ready", 32'(o_ready), 32'd0);
            i_valid = 1'b1; i_op = 2'd0; i_data1 = 6'd1; i_data2 = 6'd1;
        end
        @(negedge i_clk); #1;
        i_valid = 1'b0;

        // Reset in the middle of a divide: no pulse, outputs cleared.
        issue(2'd3, 6'd45, 6'd4, 12'd0, 6'd0, 1'b0, 0, 1'b0);
        @(negedge i_clk); #1;
        @(negedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        chk("abort_ready",  32'(o_ready),    32'd1);
        chk("abort_valid",  32'(o_valid),    32'd0);
        chk("abort_result", 32'(o_result),   32'd0);
        chk("abort_rem",    32'(o_rem),      32'd0);
        chk("abort_dz",     32'(o_div_zero), 32'd0);
        issue(2'd0, 6'd1, 6'd1, 12'd2, 6'd0, 1'b0, 1, 1'b1);

        // Reset together with an offered request: reset wins.
        @(negedge i_clk); #1;
        @(negedge i_clk); #1;
        i_rst = 1'b1; i_valid = 1'b1; i_op = 2'd2; i_data1 = 6'd7; i_data2 = 6'd7;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_valid = 1'b0;
        @(negedge i_clk); #1;
        chk("rst_accept_ready",  32'(o_ready),  32'd1);
        chk("rst_accept_result", 32'(o_result), 32'd0);

        issue(2'd1, 6'd20, 6'd7, 12'd13, 6'd0, 1'b0, 1, 1'b1);
        repeat (5) @(negedge i_clk);
        #1;
        chk("hold_result", 32'(o_result), 32'd13);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge i_clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
